decompose_seq_ctrl: RTL
=======================

# decompose_seq_ctrl

Frame sequencer for the Sym4 L1→L2→L3→L4 decomposition cascade. It accepts 16-sample parallel words from an upstream valid/ready source and drives the cascade's `din_valid`/`din` for a configured frame length. It then appends zero flush words to drain the filter taps and counts the cascade's L4 outputs. It marks the first and last L4 output of each frame, signals completion, and flags overrun and timeout errors.

## Interface
- `DATA_WIDTH`, 16: sample width.
- `LANES`, 16: samples per input word; the bus is `LANES*DATA_WIDTH` wide, lane 0 in the LSBs.
- `CNT_WIDTH`, 16: width of the frame and output counters.
- `WDOG_CYCLES`, 64: the DRAIN watchdog, in cycles without an L4 valid.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse; accepted only in IDLE.
- `abort`, in, 1: synchronous abort; acts from any state.
- `cfg_frame_len`, in, CNT_WIDTH: number of data words per frame; latched on an accepted `start`.
- `cfg_flush_len`, in, 4: number of zero words appended after the data; latched on an accepted `start`.
- `s_valid`, in, 1: upstream word valid.
- `s_ready`, out, 1: upstream ready.
- `s_data`, in, LANES*DATA_WIDTH: upstream word.
- `casc_din_valid`, out, 1: drives the cascade L1 `din_valid`.
- `casc_din`, out, LANES*DATA_WIDTH: drives the cascade L1 `din_0..din_15`.
- `casc_l4_valid`, in, 1: the cascade L4 `dout_valid`.
- `out_sof`, out, 1: marks the first L4 output of the frame.
- `out_eof`, out, 1: marks the last L4 output of the frame.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `err_cfg`, out, 1: one-cycle pulse on a rejected start.
- `err_overrun`, out, 1: one-cycle pulse on an unexpected L4 valid.
- `err_timeout`, out, 1: one-cycle pulse on a DRAIN watchdog expiry.

## Operation
States: IDLE, RUN, FLUSH, DRAIN, DONE.

- **IDLE**
  - `start` with `cfg_frame_len` ≠ 0: latch the config, clear `in_cnt`, `out_cnt` and the watchdog, and go to RUN.
  - `start` with `cfg_frame_len` = 0: pulse `err_cfg` and stay in IDLE.
- **RUN**
  - `s_ready` = 1.
  - Each handshake (`s_valid && s_ready`) registers `s_data` onto `casc_din` with `casc_din_valid` = 1 in the next cycle, and increments `in_cnt`.
  - A cycle with no handshake gives `casc_din_valid` = 0 in the next cycle, and `casc_din` holds its value.
  - The handshake that makes `in_cnt` equal the frame length transitions to FLUSH if flush_len > 0, otherwise to DRAIN. `s_ready` drops in that same transition cycle.
- **FLUSH**
  - `s_ready` = 0.
  - Drive `casc_din` = 0 with `casc_din_valid` = 1 for exactly flush_len consecutive cycles, then go to DRAIN.
- **DRAIN**
  - `casc_din_valid` = 0.
  - Expected output count E = frame_len + flush_len.
  - Go to DONE when `out_cnt` reaches E.
  - The watchdog counts cycles without `casc_l4_valid` and resets on each valid. When it reaches WDOG_CYCLES: pulse `err_timeout` and go to IDLE.
- **DONE**: one cycle; `done` = 1; then go to IDLE.
- **L4 output counting** (RUN, FLUSH and DRAIN)
  - Each `casc_l4_valid` increments `out_cnt`.
  - `out_sof` = `casc_l4_valid` && `out_cnt` = 0.
  - `out_eof` = `casc_l4_valid` && `out_cnt` = E−1.
  - Both are combinational, in the same cycle as `casc_l4_valid`.
  - A `casc_l4_valid` when `out_cnt` = E already: pulse `err_overrun` and do not count it.
  - `casc_l4_valid` in IDLE or DONE is ignored, with no error.
- **abort**
  - Takes priority over every other event in the cycle.
  - Next state is IDLE; `casc_din_valid`, `s_ready` and `busy` are 0 from the next cycle; no `done` pulse.
  - Counters clear on the next `start`.
- **Simultaneous `start` and `abort` in IDLE**: `abort` wins and `start` is dropped.
- **Widths**
  - E is computed in CNT_WIDTH+1 bits, so there is no wrap at frame_len = 2^CNT_WIDTH−1 with flush_len = 15.
  - `out_cnt` is CNT_WIDTH+1 bits wide.

## Timing
- **Reset values**: all outputs are 0, including `casc_din`; state is IDLE.
- **Input path latency**: 1 cycle from the `s_data` handshake to `casc_din`/`casc_din_valid`.
- **`s_ready`**: a registered state decode, so it does not depend combinationally on `s_valid`.
- **Flush timing**: the first flush word is on `casc_din` in the cycle after the last data word appears there, with no bubble when the upstream source streams back-to-back.
- **`busy`**: rises the cycle after an accepted `start`; falls the cycle after DONE, an abort or a timeout.
- **`done`**: asserts exactly 1 cycle after the cycle in which `out_eof` is high.
- **Reset mid-frame**: immediate IDLE; all outputs return to their reset values asynchronously.

## Test plan
1. **Nominal frame**: `start` with frame_len = 8, flush_len = 4, `s_valid` held high. Required:
   - `s_ready` high for exactly 8 cycles.
   - `casc_din_valid` high for 12 consecutive cycles, the last 4 with zero data.
   - `out_sof` on the 1st and `out_eof` on the 12th L4 valid.
   - `done` pulse one cycle after `out_eof`.
2. **Gapped upstream**: `s_valid` toggles 1,0,1,0 with frame_len = 4, flush_len = 0. Required:
   - `casc_din_valid` mirrors the handshakes, delayed 1 cycle.
   - Transition to DRAIN after the 4th handshake.
   - `done` after the 4th L4 valid.
3. **Zero-length config**: `start` with frame_len = 0. Required: `err_cfg` pulse, `busy` stays 0.
4. **Overrun**: the bench injects 13 L4 valids for an E = 12 frame. Required: `err_overrun` on the 13th, `out_eof` on the 12th only.
5. **Watchdog timeout**: frame_len = 2, flush_len = 0, 1 L4 valid returned, then silence. Required: `err_timeout` WDOG_CYCLES = 64 cycles after the last valid, no `done`, back in IDLE.
6. **Abort and reset**
   - `abort` during FLUSH: `casc_din_valid` 0 next cycle, `busy` 0, no `done`.
   - A following `start` runs a clean frame_len = 1, flush_len = 0 frame.
   - `rst_n` low mid-RUN: all outputs 0 asynchronously.

Source files
------------

// File: rtl/decompose_seq_ctrl.sv
// decompose_seq_ctrl
//
// Frame sequencer for the Sym4 L1->L2->L3->L4 decomposition cascade.
// Accepts LANES-sample parallel words from an upstream valid/ready source,
// forwards frame_len of them to the cascade input, appends flush_len zero
// words to drain the filter taps, then waits for the matching number of L4
// outputs. The first and last L4 output of the frame are marked, completion
// is pulsed, and overrun / watchdog-timeout errors are flagged.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   start, abort          frame start pulse (IDLE only), synchronous abort
//   cfg_frame_len         data words per frame, latched on accepted start
//   cfg_flush_len         zero words appended after the data, latched on start
//   s_valid/s_ready/s_data  upstream word stream, lane 0 in the LSBs
//   casc_din_valid/casc_din cascade L1 input
//   casc_l4_valid         cascade L4 output valid
//   out_sof, out_eof      first / last L4 output of the frame (combinational)
//   busy                  high in every state except IDLE
//   done                  one-cycle completion pulse
//   err_cfg               one-cycle pulse on a start with frame_len = 0
//   err_overrun           one-cycle pulse on an L4 valid beyond the frame
//   err_timeout           one-cycle pulse when the DRAIN watchdog expires

module decompose_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_WIDTH-1:0]          cfg_frame_len,
  input  logic [3:0]                    cfg_flush_len,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   s_data,
  output logic                          casc_din_valid,
  output logic [LANES*DATA_WIDTH-1:0]   casc_din,
  input  logic                          casc_l4_valid,
  output logic                          out_sof,
  output logic                          out_eof,
  output logic                          busy,
  output logic                          done,
  output logic                          err_cfg,
  output logic                          err_overrun,
  output logic                          err_timeout
);

  localparam int BUS_W  = LANES * DATA_WIDTH;
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0]   OUT_ONE    = {{CNT_WIDTH{1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0]    WDOG_ONE   = {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0]    WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                 state_q,          state_d;
  logic [CNT_WIDTH-1:0]   frame_len_q,      frame_len_d;
  logic [3:0]             flush_len_q,      flush_len_d;
  logic [CNT_WIDTH:0]     exp_q,            exp_d;
  logic [CNT_WIDTH-1:0]   in_cnt_q,         in_cnt_d;
  logic [CNT_WIDTH:0]     out_cnt_q,        out_cnt_d;
  logic [3:0]             flush_cnt_q,      flush_cnt_d;
  logic [WDOG_W-1:0]      wdog_q,           wdog_d;
  logic [BUS_W-1:0]       casc_din_q,       casc_din_d;
  logic                   casc_din_valid_q, casc_din_valid_d;
  logic                   s_ready_q,        s_ready_d;
  logic                   busy_q,           busy_d;
  logic                   done_q,           done_d;
  logic                   err_cfg_q,        err_cfg_d;
  logic                   err_overrun_q,    err_overrun_d;
  logic                   err_timeout_q,    err_timeout_d;

  logic counting;
  logic handshake;
  logic l4_hit;
  logic l4_over;

  // Classify this cycle's events. L4 valids only matter while a frame is in
  // flight; once out_cnt has reached the expected count, further valids are
  // overruns and are not counted.
  always_comb begin
    counting  = (state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
    handshake = (state_q == ST_RUN) && s_valid && s_ready_q;
    l4_over   = counting && casc_l4_valid && (out_cnt_q == exp_q);
    l4_hit    = counting && casc_l4_valid && (out_cnt_q != exp_q);
  end

  // Frame markers are combinational so they line up with the L4 valid.
  assign out_sof = l4_hit && (out_cnt_q == '0);
  assign out_eof = l4_hit && (out_cnt_q == (exp_q - OUT_ONE));

  // Next-state and next-output logic. Output flops are decoded from the next
  // state so s_ready, busy and done are registered and never depend
  // combinationally on the upstream handshake. Abort is applied last so it
  // overrides everything else decided in the cycle.
  always_comb begin
    state_d          = state_q;
    frame_len_d      = frame_len_q;
    flush_len_d      = flush_len_q;
    exp_d            = exp_q;
    in_cnt_d         = in_cnt_q;
    out_cnt_d        = out_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    wdog_d           = wdog_q;
    casc_din_d       = casc_din_q;
    casc_din_valid_d = 1'b0;
    err_cfg_d        = 1'b0;
    err_overrun_d    = 1'b0;
    err_timeout_d    = 1'b0;

    // The watchdog holds the number of cycles elapsed since the last L4
    // valid, so a valid cycle restarts it at one for the following cycle.
    if (l4_hit) begin
      out_cnt_d = out_cnt_q + OUT_ONE;
      wdog_d    = WDOG_ONE;
    end
    if (l4_over) begin
      err_overrun_d = 1'b1;
      wdog_d        = WDOG_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_frame_len != '0) begin
            frame_len_d = cfg_frame_len;
            flush_len_d = cfg_flush_len;
            // One extra bit keeps frame_len + flush_len from wrapping.
            exp_d       = {1'b0, cfg_frame_len} + {{(CNT_WIDTH-3){1'b0}}, cfg_flush_len};
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            flush_cnt_d = '0;
            wdog_d      = '0;
            state_d     = ST_RUN;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (handshake) begin
          casc_din_d       = s_data;
          casc_din_valid_d = 1'b1;
          in_cnt_d         = in_cnt_q + CNT_ONE;
          if (in_cnt_d == frame_len_q) begin
            state_d = (flush_len_q != 4'd0) ? ST_FLUSH : ST_DRAIN;
          end
        end
      end

      // Entered on the last data handshake, so the first zero word follows
      // the last data word on casc_din without a bubble.
      ST_FLUSH: begin
        casc_din_d       = '0;
        casc_din_valid_d = 1'b1;
        flush_cnt_d      = flush_cnt_q + 4'd1;
        if (flush_cnt_d == flush_len_q) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (out_cnt_d == exp_q) begin
          state_d = ST_DONE;
        end else if (!casc_l4_valid) begin
          wdog_d = wdog_q + WDOG_ONE;
          if (wdog_d == WDOG_LIMIT) begin
            err_timeout_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d          = ST_IDLE;
      casc_din_d       = casc_din_q;
      casc_din_valid_d = 1'b0;
      err_cfg_d        = 1'b0;
      err_overrun_d    = 1'b0;
      err_timeout_d    = 1'b0;
    end

    s_ready_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // State, counters and registered outputs. Reset returns every output to
  // zero immediately, including the cascade data bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      frame_len_q      <= '0;
      flush_len_q      <= '0;
      exp_q            <= '0;
      in_cnt_q         <= '0;
      out_cnt_q        <= '0;
      flush_cnt_q      <= '0;
      wdog_q           <= '0;
      casc_din_q       <= '0;
      casc_din_valid_q <= 1'b0;
      s_ready_q        <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_cfg_q        <= 1'b0;
      err_overrun_q    <= 1'b0;
      err_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_len_q      <= frame_len_d;
      flush_len_q      <= flush_len_d;
      exp_q            <= exp_d;
      in_cnt_q         <= in_cnt_d;
      out_cnt_q        <= out_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
      wdog_q           <= wdog_d;
      casc_din_q       <= casc_din_d;
      casc_din_valid_q <= casc_din_valid_d;
      s_ready_q        <= s_ready_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_cfg_q        <= err_cfg_d;
      err_overrun_q    <= err_overrun_d;
      err_timeout_q    <= err_timeout_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign casc_din       = casc_din_q;
  assign casc_din_valid = casc_din_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cfg        = err_cfg_q;
  assign err_overrun    = err_overrun_q;
  assign err_timeout    = err_timeout_q;

endmodule
